led_mode_sched: RTL and testbench

Sequencing controller for the 12-bit LED pattern engine. It derives the pattern step rate from `clk` with a programmable divider and debounces two push-buttons (next, pause). It decides which pattern mode the engine runs and when that mode advances, either automatically on pattern completion or manually. Outputs are one-cycle step strobes, a mode code and a clear strobe, which drive the engine directly.

---
 rtl/led_mode_sched.sv | 151 +++++++++++++++
 tb/tb_led_mode_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_sched.sv
// rtl/led_mode_sched.sv - mode sequencer, step-rate divider and button debounce for the LED pattern engine
// Buttons are synchronized and debounced into one-cycle press events; the FSM picks the mode and gates steps.
module led_mode_sched #(
   parameter int unsigned DEFAULT_DIV = 12_500_000,
   parameter int unsigned DB_CYCLES   = 1_000_000,
   parameter int unsigned DIV_W       = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_pause,
   input  logic       auto_en,
   input  logic [1:0] div_sel,
   input  logic       pat_done,
   output logic       step,
   output logic       clr,
   output logic [2:0] mode,
   output logic       paused
);

   typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_RUN, S_PAUSE} state_t;

   localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(DEFAULT_DIV);

   function automatic logic [DIV_W-1:0] period_of(input logic [1:0] sel);
      logic [DIV_W-1:0] p;
      p = DIV_BASE >> sel;
      return (p == '0) ? DIV_W'(1) : p;
   endfunction

   function automatic logic [2:0] next_mode(input logic [2:0] m);
      case (m)
         3'd1:    return 3'd2;
         3'd2:    return 3'd3;
         3'd3:    return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   // Index 0 = next, index 1 = pause.
   logic [1:0]      btn_raw;
   logic [1:0]      sync1_q, sync2_q, lvl_q, lvl_prev_q, evt_q;
   logic [DB_W-1:0] db_cnt_q [2];
   logic            next_evt, pause_evt;

   assign btn_raw   = {btn_pause, btn_next};
   assign next_evt  = evt_q[0];
   assign pause_evt = evt_q[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         lvl_q      <= '0;
         lvl_prev_q <= '0;
         evt_q      <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         lvl_prev_q <= lvl_q;
         evt_q      <= lvl_q & ~lvl_prev_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
               lvl_q[i]    <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d, period_q, period_d;
   logic [2:0]       mode_q, mode_d;
   logic             step_q, step_d, clr_q, clr_d, paused_q, paused_d;
   logic             tick, hold;

   assign tick = (div_cnt_q == period_q - DIV_W'(1));

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (next_evt || (tick && auto_en)) begin
               state_d = S_SWITCH;
               mode_d  = 3'd1;
            end
         end
         S_SWITCH: state_d = S_RUN;
         S_RUN: begin
            if (next_evt) begin
               state_d = S_SWITCH;
               mode_d  = next_mode(mode_q);
            end else if (pause_evt) begin
               state_d = S_PAUSE;
            end else if (pat_done && auto_en) begin
               state_d = S_SWITCH;
               mode_d  = next_mode(mode_q);
            end
         end
         S_PAUSE: begin
            if (pause_evt) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase

      // Freeze the count on the entry and exit edges of PAUSE so the resumed period finishes exactly.
      hold = (state_q == S_PAUSE) || (state_d == S_PAUSE);
      if (state_d == S_SWITCH)  div_cnt_d = '0;
      else if (hold)            div_cnt_d = div_cnt_q;
      else if (tick)            div_cnt_d = '0;
      else                      div_cnt_d = div_cnt_q + DIV_W'(1);

      period_d = (!hold && tick) ? period_of(div_sel) : period_q;
      step_d   = (state_q == S_RUN) && tick;
      clr_d    = (state_d == S_SWITCH);
      paused_d = (state_d == S_PAUSE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         div_cnt_q <= '0;
         period_q  <= period_of(div_sel);
         mode_q    <= '0;
         step_q    <= 1'b0;
         clr_q     <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         period_q  <= period_d;
         mode_q    <= mode_d;
         step_q    <= step_d;
         clr_q     <= clr_d;
         paused_q  <= paused_d;
      end
   end

   assign step   = step_q;
   assign clr    = clr_q;
   assign mode   = mode_q;
   assign paused = paused_q;

endmodule

// File: tb/tb_led_mode_sched.sv
// tb/tb_led_mode_sched.sv - directed self-checking bench for led_mode_sched
// Runs with DEFAULT_DIV=8 and DB_CYCLES=4; a button press acts 8 edges after it is applied.
module tb_led_mode_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_pause = 1'b0;
   logic       auto_en = 1'b1;
   logic [1:0] div_sel = 2'd0;
   logic       pat_done = 1'b0;
   logic       step, clr, paused;
   logic [2:0] mode;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   led_mode_sched #(.DEFAULT_DIV(8), .DB_CYCLES(4), .DIV_W(32)) dut (
      .clk(clk), .rst(rst), .btn_next(btn_next), .btn_pause(btn_pause),
      .auto_en(auto_en), .div_sel(div_sel), .pat_done(pat_done),
      .step(step), .clr(clr), .mode(mode), .paused(paused)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      int n;
      rst = 1'b0; auto_en = 1'b1; div_sel = 2'd0;
      cyc(3);
      tests++; if (step !== 1'b0)   begin fails++; $display("FAIL reset_step: got %b want 0", step); end
      tests++; if (clr !== 1'b0)    begin fails++; $display("FAIL reset_clr: got %b want 0", clr); end
      tests++; if (mode !== 3'd0)   begin fails++; $display("FAIL reset_mode: got %0d want 0", mode); end
      tests++; if (paused !== 1'b0) begin fails++; $display("FAIL reset_paused: got %b want 0", paused); end
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 7; i++) begin cyc(1); if (clr || step) n++; end
      tests++; if (n != 0) begin fails++; $display("FAIL reset_quiet: got %0d pulses want 0", n); end
      cyc(1);
      tests++; if (clr !== 1'b1)  begin fails++; $display("FAIL start_clr: got %b want 1", clr); end
      tests++; if (mode !== 3'd1) begin fails++; $display("FAIL start_mode: got %0d want 1", mode); end
      for (int k = 0; k < 2; k++) begin
         n = 0;
         for (int i = 0; i < 7; i++) begin cyc(1); if (step) n++; end
         cyc(1);
         tests++; if (n != 0 || step !== 1'b1) begin
            fails++; $display("FAIL step_cadence%0d: early=%0d step=%b want early=0 step=1", k, n, step);
         end
      end
   endtask

   task automatic test_auto_advance;
      logic [2:0] exp_m [4];
      int n;
      exp_m = '{3'd2, 3'd3, 3'd4, 3'd1};
      for (int k = 0; k < 4; k++) begin
         pat_done = 1'b1; cyc(1); pat_done = 1'b0;
         tests++; if (clr !== 1'b1 || mode !== exp_m[k]) begin
            fails++; $display("FAIL auto_adv%0d: clr=%b mode=%0d want clr=1 mode=%0d", k, clr, mode, exp_m[k]);
         end
         n = 0;
         for (int i = 0; i < 7; i++) begin cyc(1); if (step || clr) n++; end
         tests++; if (n != 0) begin fails++; $display("FAIL auto_quiet%0d: got %0d pulses want 0", k, n); end
         cyc(1);
         tests++; if (step !== 1'b1) begin fails++; $display("FAIL auto_step%0d: got %b want 1", k, step); end
      end
   endtask

   task automatic test_manual_repeat;
      int n;
      pat_done = 1'b1; cyc(1); pat_done = 1'b0;
      cyc(8);
      auto_en = 1'b0;
      cyc(3);
      pat_done = 1'b1; cyc(1); pat_done = 1'b0;
      tests++; if (clr !== 1'b0 || mode !== 3'd2) begin
         fails++; $display("FAIL manual_hold: clr=%b mode=%0d want clr=0 mode=2", clr, mode);
      end
      n = 0;
      for (int i = 0; i < 3; i++) begin cyc(1); if (step || clr) n++; end
      cyc(1);
      tests++; if (n != 0 || step !== 1'b1 || mode !== 3'd2) begin
         fails++; $display("FAIL manual_cadence: early=%0d step=%b mode=%0d want 0 1 2", n, step, mode);
      end
      auto_en = 1'b1;
   endtask

   task automatic test_debounce;
      int n;
      btn_next = 1'b1; cyc(3); btn_next = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin cyc(1); if (clr) n++; end
      tests++; if (n != 0 || mode !== 3'd2) begin
         fails++; $display("FAIL glitch: clr_count=%0d mode=%0d want 0 2", n, mode);
      end
      btn_next = 1'b1;
      cyc(7);
      pat_done = 1'b1; cyc(1); pat_done = 1'b0;
      tests++; if (clr !== 1'b1 || mode !== 3'd3) begin
         fails++; $display("FAIL coincident: clr=%b mode=%0d want clr=1 mode=3", clr, mode);
      end
      n = 0;
      for (int i = 0; i < 14; i++) begin cyc(1); if (i == 1) btn_next = 1'b0; if (clr) n++; end
      tests++; if (n != 0 || mode !== 3'd3) begin
         fails++; $display("FAIL coincident_once: extra_clr=%0d mode=%0d want 0 3", n, mode);
      end
      btn_next = 1'b1;
      n = 0;
      for (int i = 0; i < 7; i++) begin cyc(1); if (clr) n++; end
      cyc(1);
      tests++; if (n != 0 || clr !== 1'b1 || mode !== 3'd4) begin
         fails++; $display("FAIL press_latency: early=%0d clr=%b mode=%0d want 0 1 4", n, clr, mode);
      end
      cyc(2); btn_next = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin cyc(1); if (clr) n++; end
      tests++; if (n != 0 || mode !== 3'd4) begin
         fails++; $display("FAIL press_once: extra_clr=%0d mode=%0d want 0 4", n, mode);
      end
   endtask

   task automatic test_pause;
      int w, n, nc;
      w = 0;
      while (step !== 1'b1 && w < 20) begin cyc(1); w++; end
      tests++; if (step !== 1'b1) begin fails++; $display("FAIL pause_sync: no step within %0d cycles", w); end
      cyc(6); btn_pause = 1'b1;
      cyc(7);
      tests++; if (paused !== 1'b0) begin fails++; $display("FAIL pause_early: got %b want 0", paused); end
      cyc(1);
      tests++; if (paused !== 1'b1) begin fails++; $display("FAIL pause_enter: got %b want 1", paused); end
      cyc(2); btn_pause = 1'b0;
      btn_next = 1'b1;
      n = 0; nc = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (i == 9) btn_next = 1'b0;
         if (step) n++;
         if (clr) nc++;
      end
      tests++; if (n != 0 || nc != 0 || mode !== 3'd4 || paused !== 1'b1) begin
         fails++; $display("FAIL paused_idle: steps=%0d clrs=%0d mode=%0d paused=%b want 0 0 4 1", n, nc, mode, paused);
      end
      btn_pause = 1'b1;
      n = 0;
      for (int i = 0; i < 7; i++) begin cyc(1); if (step) n++; end
      tests++; if (n != 0 || paused !== 1'b1) begin
         fails++; $display("FAIL resume_early: steps=%0d paused=%b want 0 1", n, paused);
      end
      cyc(1);
      tests++; if (paused !== 1'b0) begin fails++; $display("FAIL resume_edge: paused=%b want 0", paused); end
      n = 0;
      for (int i = 0; i < 2; i++) begin cyc(1); if (step) n++; end
      cyc(1);
      tests++; if (n != 0 || step !== 1'b1) begin
         fails++; $display("FAIL resume_step: early=%0d step=%b want 0 1", n, step);
      end
      btn_pause = 1'b0;
   endtask

   task automatic test_speed;
      int n;
      logic exp_s [4];
      exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
      cyc(3); div_sel = 2'd2;
      n = 0;
      for (int i = 0; i < 4; i++) begin cyc(1); if (step) n++; end
      cyc(1);
      tests++; if (n != 0 || step !== 1'b1) begin
         fails++; $display("FAIL speed_finish: early=%0d step=%b want 0 1", n, step);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         tests++; if (step !== exp_s[i]) begin fails++; $display("FAIL speed_div4_%0d: got %b want %b", i, step, exp_s[i]); end
      end
      div_sel = 2'd3;
      cyc(1);
      tests++; if (step !== 1'b0) begin fails++; $display("FAIL speed_last2: got %b want 0", step); end
      n = 0;
      for (int i = 0; i < 5; i++) begin cyc(1); if (step) n++; end
      tests++; if (n != 5) begin fails++; $display("FAIL speed_div1: got %0d steps want 5", n); end
   endtask

   task automatic test_reset_in_pause;
      int n;
      btn_pause = 1'b1;
      cyc(8);
      tests++; if (paused !== 1'b1) begin fails++; $display("FAIL rp_enter: got %b want 1", paused); end
      rst = 1'b0;
      #1;
      tests++; if (step !== 1'b0 || clr !== 1'b0 || mode !== 3'd0 || paused !== 1'b0) begin
         fails++; $display("FAIL rp_async: step=%b clr=%b mode=%0d paused=%b want 0 0 0 0", step, clr, mode, paused);
      end
      btn_pause = 1'b0; div_sel = 2'd0;
      cyc(3);
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 7; i++) begin cyc(1); if (clr || step) n++; end
      cyc(1);
      tests++; if (n != 0 || clr !== 1'b1 || mode !== 3'd1) begin
         fails++; $display("FAIL rp_restart: early=%0d clr=%b mode=%0d want 0 1 1", n, clr, mode);
      end
   endtask

   initial begin
      test_reset();
      test_auto_advance();
      test_manual_repeat();
      test_debounce();
      test_pause();
      test_speed();
      test_reset_in_pause();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule
